phase_sequencer: RTL
====================

// Module: phase_sequencer
// PURPOSE
//  Upstream feeder of the control unit: debounces the raw active-low exec button,
//  runs the run/step/halt state machine and generates the 3-bit phase count (0..4).
//  phase/running drive the control unit's phase inputs; halt comes from the datapath.
//  Supports free-run and single-instruction step mode; counts retired instructions.
// PARAMETERS
//  DEBOUNCE_CNT  20000  cycles a synchronized input must be stable to change level (>=2)
//  CNT_W         16     width of debounce counter; must hold DEBOUNCE_CNT-1
//  IC_W          16     width of instr_count
// PORTS
//  clock        in   1     system clock, all logic on posedge
//  reset        in   1     synchronous, active-low
//  exec_n       in   1     raw exec push button, active-low, asynchronous, bouncy
//  step_mode    in   1     1 = single-instruction step, 0 = free run; sampled at start
//  halt         in   1     halt request from datapath, sampled only in phase 4
//  phase        out  3     current phase 0..4
//  running      out  1     1 while sequencing (RUN or STEP)
//  instr_done   out  1     one-cycle pulse in the cycle phase==4 is active
//  instr_count  out  IC_W  completed instructions, wraps modulo 2^IC_W
//  state        out  2     FSM state: 0 IDLE, 1 RUN, 2 STEP, 3 HALTED
// BEHAVIOUR
//  Reset (reset==0 at posedge, overrides everything): state IDLE, phase 0, running 0,
//   instr_done 0, instr_count 0, stop_req 0, sync flops 1, db_level 1, debounce cnt 0.
//  Synchronizer: 2 flops on exec_n. Debounce: if sync!=db_level cnt++, and when
//   cnt==DEBOUNCE_CNT-1 with sync still differing: db_level<=sync, cnt<=0;
//   if sync==db_level cnt<=0. press = one-cycle pulse on db_level 1->0; release ignored.
//  All outputs registered. phase holds 0 outside RUN/STEP; in RUN/STEP it goes
//   0,1,2,3,4,0,... one step per clock; phase never takes values 5..7.
//  instr_done==1 exactly when running==1 and phase==4; instr_count increments on the
//   clock edge ending that cycle.
//  IDLE: press -> STEP if step_mode==1 else RUN; running=1 and phase=0 on the next
//   cycle. step_mode is ignored at all other times.
//  RUN: press sets stop_req. At phase 4: if halt -> HALTED; else if stop_req or press
//   (same cycle) -> IDLE; else continue with phase 0. stop_req clears when leaving RUN.
//  STEP: presses ignored. At phase 4: halt -> HALTED, else -> IDLE. One step = 5 cycles.
//  HALTED: running 0, phase 0; press -> IDLE (a second press is needed to restart).
//  Priority at phase 4: reset > halt > stop > continue. halt in phases 0..3 ignored.
//  An instruction is never truncated: leaving RUN/STEP happens only after phase 4.
//  instr_count wraps from 2^IC_W-1 to 0 without flag.
// TESTING  (bench uses DEBOUNCE_CNT=4)
//  1 reset=0 for 3 clocks with exec_n=0 -> state 0, phase 0, running 0, count 0, no start.
//  2 exec_n low for 2 clocks then high -> no state change; exec_n held low -> running=1
//    7 clocks after the fall (2 sync + 4 debounce + 1 FSM), phase=0, state=1.
//  3 free run 20 clocks from phase 0 -> phases 0,1,2,3,4 repeating, instr_done every
//    5th cycle, instr_count=4.
//  4 halt=1 only in phase 2 -> ignored; halt=1 in phase 4 -> next cycle state=3, phase 0,
//    running 0, count incremented by 1; press -> state 0.
//  5 step_mode=1, press -> running high exactly 5 cycles (phases 0..4), count +1, state 0;
//    press during the step does not extend it.
//  6 press in RUN at phase 1 -> stop at phase 4 end, state 0; reset=0 during phase 3 of
//    another run -> next cycle phase 0, state 0, count 0.

Source files
------------

// File: rtl/phase_sequencer.sv
// phase_sequencer: debounces the exec button and runs the run/step/halt FSM producing phases 0..4
module phase_sequencer #(
  parameter int DEBOUNCE_CNT = 20000,
  parameter int CNT_W = 16,
  parameter int IC_W = 16
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            exec_n,
  input  logic            step_mode,
  input  logic            halt,
  output logic [2:0]      phase,
  output logic            running,
  output logic            instr_done,
  output logic [IC_W-1:0] instr_count,
  output logic [1:0]      state
);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, STEP = 2'd2, HALTED = 2'd3;
  logic sync1, sync2, db_level, db_prev, press, stop_req, stop_next;
  logic running_next, done_next, last;
  logic [CNT_W-1:0] cnt;
  logic [1:0] state_next;
  logic [2:0] phase_next;
  always_ff @(posedge clock) begin
    if (!reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      db_level <= 1'b1;
      db_prev <= 1'b1;
      cnt <= '0;
    end else begin
      sync1 <= exec_n;
      sync2 <= sync1;
      db_prev <= db_level;
      if (sync2 == db_level) cnt <= '0;
      else if (cnt == CNT_W'(DEBOUNCE_CNT - 1)) begin
        db_level <= sync2;
        cnt <= '0;
      end else cnt <= cnt + 1'b1;
    end
  end
  // only the falling edge of the debounced level counts as a press
  assign press = db_prev & ~db_level;
  assign last = phase == 3'd4;
  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= IDLE;
      phase <= 3'd0;
      running <= 1'b0;
      instr_done <= 1'b0;
      instr_count <= '0;
      stop_req <= 1'b0;
    end else begin
      state <= state_next;
      phase <= phase_next;
      running <= running_next;
      instr_done <= done_next;
      stop_req <= stop_next;
      if (instr_done) instr_count <= instr_count + 1'b1;
    end
  end
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = press ? (step_mode ? STEP : RUN) : IDLE;
      RUN:     state_next = !last ? RUN : halt ? HALTED : (stop_req | press) ? IDLE : RUN;
      STEP:    state_next = !last ? STEP : halt ? HALTED : IDLE;
      default: state_next = press ? IDLE : HALTED;
    endcase
  end
  always_comb begin
    running_next = state_next == RUN || state_next == STEP;
    phase_next = (running_next && state_next == state && !last) ? phase + 3'd1 : 3'd0;
    done_next = running_next && phase_next == 3'd4;
    stop_next = state == RUN && state_next == RUN && (stop_req | press);
  end
endmodule
